// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
package tick_gen_pkg;

    localparam int TICK_CNT_W   = 25;
    localparam int TICK_DEF_DIV = 25_000_000;

    function automatic int ch_idx_w(input int num_ch);
        int w;
        w = 32'sd1;
        while ((32'sd1 <<< w) < num_ch) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Run/resync controls, divisor configuration handshake and tick outputs.
interface tick_gen_if #(
    parameter int CNT_W  = tick_gen_pkg::TICK_CNT_W,
    parameter int NUM_CH = 2,
    parameter int CH_W   = tick_gen_pkg::ch_idx_w(NUM_CH)
);

    logic              en;
    logic              resync;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, resync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick
    );

    modport slave (
        input  en, resync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick
    );

endinterface

// File: rtl/tick_gen_chan.sv
// One tick channel: wrap counter, active/shadow divisor pair with pending flag,
// and the registered tick pulse.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = TICK_CNT_W,
    parameter int DEF_DIV = TICK_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r, div_r, shadow_r;
    logic             pending_r, tick_r;
    logic [CNT_W-1:0] cnt_s, div_s, shadow_s;
    logic             pending_s, tick_s;
    logic             term_s;
    logic             idle_s;

    assign idle_s = (div_r == ZERO);
    assign term_s = !idle_s && (cnt_r == div_r - ONE);

    // Next-state: resync and wraps swap in the shadow; a write this cycle lands afterwards.
    always_comb begin
        cnt_s     = cnt_r;
        div_s     = div_r;
        shadow_s  = shadow_r;
        pending_s = pending_r;
        tick_s    = 1'b0;

        if (resync || idle_s || (en && term_s)) begin
            cnt_s     = ZERO;
            div_s     = pending_r ? shadow_r : div_r;
            pending_s = 1'b0;
            tick_s    = !resync && !idle_s;
        end else if (en) begin
            cnt_s = cnt_r + ONE;
        end else begin
            cnt_s = cnt_r;
        end

        // A disabled channel has no period to protect, so it takes the divisor at once.
        if (wr) begin
            shadow_s = wr_div;
            if (idle_s && !resync) begin
                div_s     = wr_div;
                pending_s = 1'b0;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            shadow_s = shadow_r;
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= ZERO;
            div_r     <= RST_DIV;
            shadow_r  <= RST_DIV;
            pending_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            shadow_r  <= shadow_s;
            pending_r <= pending_s;
            tick_r    <= tick_s;
        end
    end

    assign tick    = tick_r;
    assign pending = pending_r;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: configuration decode, ready mux
// and one tick_chan per channel.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = TICK_CNT_W,
    parameter int NUM_CH  = 2,
    parameter int DEF_DIV = TICK_DEF_DIV
) (
    input  logic      clk,
    input  logic      rst,
    tick_gen_if.slave bus
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] pending_s;
    logic [NUM_CH-1:0] tick_s;
    logic [NUM_CH-1:0] wr_s;
    logic              ready_sel_s;
    logic              ready_s;

    // Out-of-range indices match no channel, so they read ready and the write is dropped.
    always_comb begin
        ready_sel_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ready_sel_s = (bus.cfg_ch == CH_W'(i)) ? !pending_s[i] : ready_sel_s;
        end
    end

    assign ready_s = ready_sel_s && !rst;

    // Per-channel write strobes for accepted configuration transfers.
    always_comb begin
        wr_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            wr_s[i] = bus.cfg_valid && ready_s && (bus.cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .resync  (bus.resync),
            .wr      (wr_s[g]),
            .wr_div  (bus.cfg_div),
            .tick    (tick_s[g]),
            .pending (pending_s[g])
        );
    end

    assign bus.cfg_ready = ready_s;
    assign bus.tick      = tick_s;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: table of per-cycle vectors plus a resync/write
// collision sequence.
module tb_tick_gen;

    logic clk = 1'b0;
    logic rst;

    tick_gen_if #(.CNT_W(4), .NUM_CH(2)) bus ();

    tick_gen #(
        .CNT_W   (4),
        .NUM_CH  (2),
        .DEF_DIV (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic       en;
        logic       resync;
        logic       cfg_valid;
        logic       cfg_ch;
        logic [3:0] cfg_div;
        logic [1:0] exp_tick;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit r, input logic e, input logic s, input logic v,
                       input logic c, input logic [3:0] d, input logic [1:0] t,
                       input logic rdy);
        vec_t x;
        x.do_rst = r; x.en = e; x.resync = s; x.cfg_valid = v;
        x.cfg_ch = c; x.cfg_div = d; x.exp_tick = t; x.exp_ready = rdy;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] act,
                         input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic do_reset(input int idx);
        rst = 1'b1;
        bus.en = 1'b0; bus.resync = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_ch = 1'b0; bus.cfg_div = 4'd0;
        #1;
        check("reset_ready", idx, {1'b0, bus.cfg_ready}, 2'b00);
        @(posedge clk); #1;
        check("reset_tick", idx, bus.tick, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive one cycle's inputs, check ready before the edge and tick after it.
    task automatic apply(input vec_t v, input int idx, input string tag);
        if (v.do_rst) do_reset(idx);
        bus.en = v.en; bus.resync = v.resync; bus.cfg_valid = v.cfg_valid;
        bus.cfg_ch = v.cfg_ch; bus.cfg_div = v.cfg_div;
        #1;
        check({tag, "_ready"}, idx, {1'b0, bus.cfg_ready}, {1'b0, v.exp_ready});
        @(posedge clk); #1;
        check({tag, "_tick"}, idx, bus.tick, v.exp_tick);
    endtask

    initial begin
        int t;
        logic [1:0] et;
        vec_t x;

        rst = 1'b1;
        bus.en = 1'b0; bus.resync = 1'b0; bus.cfg_valid = 1'b0;
        bus.cfg_ch = 1'b0; bus.cfg_div = 4'd0;

        // Free run at the reset divisor: ticks at 5, 10, 15.
        for (int c = 0; c < 16; c++) begin
            t = c + 1;
            add(c == 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, (t % 5 == 0) ? 2'b11 : 2'b00, 1'b1);
        end
        // ch1 div=3 written at count 2: pending until wrap at 5, then every 3.
        for (int c = 0; c < 21; c++) begin
            t = c + 1;
            et[0] = (t % 5 == 0);
            et[1] = (t == 5) || (t > 5 && (t - 5) % 3 == 0);
            add(c == 0, 1'b1, 1'b0, c == 2, 1'b1, 4'd3, et, !(c == 3 || c == 4));
        end
        // en low four cycles at count 3: next tick two cycles after en returns.
        for (int c = 0; c < 10; c++) begin
            t = c + 1;
            add(c == 0, !(c >= 3 && c <= 6), 1'b0, 1'b0, 1'b0, 4'd0,
                (t == 9) ? 2'b11 : 2'b00, 1'b1);
        end
        // Phase-shift ch1 then resync twice, the second on a shared terminal count.
        for (int c = 0; c < 27; c++) begin
            t = c + 1;
            case (t)
                5:       et = 2'b11;
                8:       et = 2'b10;
                10:      et = 2'b01;
                17, 27:  et = 2'b11;
                default: et = 2'b00;
            endcase
            add(c == 0, c != 11, (c == 11 || c == 21), (c == 0 || c == 5), 1'b1,
                (c == 0) ? 4'd3 : 4'd5, et,
                !((c >= 1 && c <= 4) || c == 6 || c == 7));
        end
        // ch0 div=0 after its period, then div=1; ch1 write left pending before reset.
        for (int c = 0; c < 12; c++) begin
            t = c + 1;
            case (t)
                5, 10:   et = 2'b11;
                9, 11, 12: et = 2'b01;
                default: et = 2'b00;
            endcase
            add(c == 0, 1'b1, 1'b0, (c == 0 || c == 7 || c == 11), c == 11,
                (c == 0) ? 4'd0 : ((c == 7) ? 4'd1 : 4'd3), et, !(c >= 1 && c <= 4));
        end
        // Reset mid-period: pending ch1 write dropped, defaults restored.
        for (int c = 0; c < 9; c++) begin
            t = c + 1;
            add(c == 0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, (t == 5) ? 2'b11 : 2'b00, 1'b1);
        end

        foreach (vecs[i]) apply(vecs[i], i, "vec");

        // Write accepted alongside resync stays pending until the next wrap.
        do_reset(1000);
        x.do_rst = 1'b0; x.en = 1'b1; x.resync = 1'b1; x.cfg_valid = 1'b1;
        x.cfg_ch = 1'b0; x.cfg_div = 4'd2; x.exp_tick = 2'b00; x.exp_ready = 1'b1;
        apply(x, 0, "rsw");
        for (int c = 1; c < 12; c++) begin
            t = c + 1;
            case (t)
                6:         et = 2'b11;
                8, 10, 12: et = 2'b01;
                11:        et = 2'b10;
                default:   et = 2'b00;
            endcase
            x.resync = 1'b0; x.cfg_valid = 1'b0; x.cfg_div = 4'd0;
            x.exp_tick = et; x.exp_ready = (c >= 6);
            apply(x, c, "rsw");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 25, counter and divisor width in bits.
REQ-002 SHALL have parameter NUM_CH, default 2, number of independent tick channels (1..16).
REQ-003 SHALL have parameter DEF_DIV, default 25_000_000, reset divisor of every channel (2 Hz from 50 MHz).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port en, input, 1, global run; low freezes all counters.
REQ-007 SHALL have port resync, input, 1, single-cycle pulse that phase-aligns all channels.
REQ-008 SHALL have port cfg_valid, input, 1, divisor update request.
REQ-009 SHALL have port cfg_ch, input, clog2(NUM_CH) (min 1), target channel index.
REQ-010 SHALL have port cfg_div, input, CNT_W, new divisor (period in clk cycles).
REQ-011 SHALL have port cfg_ready, output, 1, update accepted when cfg_valid and cfg_ready are both high.
REQ-012 SHALL have port tick, output, NUM_CH, per-channel one-cycle enable pulse, registered.

Function
REQ-013 Per channel: counter counts 0..div-1 and wraps to 0 while en=1; div is the active divisor.
REQ-014 If counter==div-1 in cycle t with en=1, tick[ch] SHALL be 1 in cycle t+1 only, and counter SHALL be 0 in t+1; the period is exactly div cycles.
REQ-015 div==1: tick[ch] SHALL be high in every cycle following a cycle with en=1.
REQ-016 div==0: channel disabled; counter held 0, tick[ch]=0.
REQ-017 en=0: counters hold value; tick SHALL be 0 in the following cycle; counting resumes from the held value when en returns.
REQ-018 Each channel SHALL have a shadow divisor and a pending flag; accepting a cfg write stores cfg_div in the shadow and sets pending.
REQ-019 cfg_ready SHALL be combinational: !pending[cfg_ch] and !rst; an out-of-range cfg_ch SHALL give cfg_ready=1 and the write is discarded.
REQ-020 A pending divisor SHALL become active at the channel's next wrap (cycle the counter goes to 0) and pending SHALL clear in the same cycle; the current period completes unaltered (glitch-free).
REQ-021 If the active div is 0 when the write is accepted, the new divisor SHALL become active in the next cycle with counter=0 and pending clear.
REQ-022 resync=1 SHALL set every counter to 0 in the next cycle, apply all pending divisors, clear all pending flags and suppress tick in that cycle, even if a terminal count coincides.
REQ-023 resync SHALL act regardless of en.
REQ-024 A cfg write accepted in the same cycle as resync SHALL remain pending (resync applies only previously pending values).
REQ-025 A cfg write accepted in the same cycle as that channel's wrap SHALL take effect at the following wrap.
REQ-026 Counter arithmetic SHALL be CNT_W-bit unsigned; comparison uses div-1 computed without underflow for div>=1.

Reset
REQ-027 While rst=1: all counters 0, tick all 0, active and shadow divisors DEF_DIV[CNT_W-1:0], pending all 0, cfg_ready 0.
REQ-028 Reset asserted mid-period SHALL abandon the period and discard pending updates; the first tick after release SHALL occur DEF_DIV cycles after the first cycle with en=1.

Structure
REQ-029 Package tick_gen_pkg SHALL hold the default constants (CNT_W, DEF_DIV) and the clog2 helper for the channel-index width.
REQ-030 Each channel SHALL be one instance of sub-module tick_chan (counter, active/shadow divisor, pending, tick register); tick_gen holds cfg decode, cfg_ready mux and the generate loop.

Verification
REQ-031 Bench parameters: CNT_W=4, NUM_CH=2, DEF_DIV=5.
REQ-032 Reset, then en=1 held -> tick[0] and tick[1] high on cycles 5, 10, 15 after release, each one cycle wide.
REQ-033 Write ch1 div=3 at counter 2 -> cfg_ready[ch1] low until the wrap; the ch1 period that is running completes at 5, then ticks every 3 cycles; ch0 is unchanged.
REQ-034 en low for 4 cycles at counter 3 -> no ticks during the pause; the next tick arrives 2 cycles after en rises.
REQ-035 Channels at different phases, resync pulsed -> both counters 0 in the next cycle with no tick; both tick together 5 cycles later; resync coinciding with a terminal count -> no tick.
REQ-036 Write div=0, then div=1 -> tick stays low during div=0; with div=1, tick is high every cycle from the cycle after activation; with rst mid-period, tick is 0 and pending is cleared.
